matmul_c_engine: RTL and testbench
==================================

// Module: matmul_c_engine
// PURPOSE
//   Consumer stage for the matrix operand memories: waits until matrix A (N x P) and
//   matrix B (P x M) loaders report write-complete. Then reads both through their
//   1-cycle-latency read ports, computes C = A*B by sequential multiply-accumulate,
//   and writes each C element through a memory write port. Single-shot per reset.
// PARAMETERS
//   N   2   rows of A / rows of C
//   P   4   cols of A = rows of B (inner dimension)
//   M   3   cols of B / cols of C
//   DW  32  operand and result width (unsigned)
//   AW  8   address width of the A, B and C ports; N*P, P*M, N*M must each be <= 2**AW
// PORTS
//   clk       in   1    clock, all logic on rising edge
//   reset     in   1    asynchronous, active-high
//   wrA_done  in   1    A memory fully loaded (level)
//   wrB_done  in   1    B memory fully loaded (level)
//   addrbA    out  AW   A read address, row-major i*P+k
//   doutbA    in   DW   A read data, valid the cycle after addrbA is presented
//   addrbB    out  AW   B read address, row-major k*M+j
//   doutbB    in   DW   B read data, valid the cycle after addrbB is presented
//   weC       out  1    C write strobe, one cycle per element
//   addrC     out  AW   C write address, row-major i*M+j
//   dinC      out  DW   C write data
//   busy      out  1    high from the start of computation until DONE
//   mm_done   out  1    high in DONE and held there until reset
// BEHAVIOUR
//   Reset (async): state=IDLE; i, j, k, acc = 0; addrbA, addrbB, weC, addrC, dinC = 0;
//     busy = 0; mm_done = 0.
//   FSM
//     IDLE -> ISSUE when wrA_done & wrB_done are both sampled high. busy rises on
//       the same edge.
//     ISSUE: P cycles. Each cycle drives addrbA = i*P+k and addrbB = k*M+j.
//       k runs 0..P-1. acc is cleared on the first ISSUE cycle of each element.
//     MAC pipe: one cycle after each ISSUE cycle, acc += doutbA*doutbB.
//       The product is a full 2*DW-bit value. acc is 2*DW+clog2(P) bits wide and
//       never wraps internally.
//     DRAIN: 1 cycle, absorbing the last MAC.
//     WRITE: 1 cycle. weC=1, addrC=i*M+j, dinC=result(acc).
//       Then j++; on j wrap to 0, i++.
//       Go to ISSUE, or to DONE after element (N-1, M-1).
//     DONE: weC=0, busy=0, mm_done=1. Terminal until reset.
//   Per-element latency: P+2 cycles. Total from the start edge to mm_done = N*M*(P+2)+1 cycles.
//   Outside WRITE, weC=0. addrC and dinC hold their last written values.
//   While busy, wrA_done and wrB_done are ignored; deassertion does not abort the run.
//   Both done inputs already high at reset release: the run starts on the first clk edge.
//   Reset mid-run: aborts immediately to the reset state. C contents already written
//     are left as-is, and the next run rewrites every element.
//   result(acc) default: acc[DW-1:0], so the value wraps modulo 2**DW.
//   Addresses are computed by counters and adders, with no multipliers in the
//   address path.
// CONFIGURATION
//   MATMUL_SAT_EN defined: result = acc > 2**DW-1 ? {DW{1'b1}} : acc[DW-1:0],
//     i.e. unsigned saturation of each C element.
//   MATMUL_SAT_EN undefined: result is truncated (wraps).
//   Ports and timing are identical either way.
// TESTING
//   1 Nominal: A=[1 2 3 4; 5 6 7 8], B=[10 20 30; 40 50 60; 70 80 90; 100 110 120].
//     Expect weC at addrC 0..5 with dinC 700, 800, 900, 1580, 1840, 2100.
//     mm_done rises 37 cycles after the start edge.
//   2 Gating: wrA_done=1 and wrB_done=0 for 20 cycles -> busy=0, no weC, addresses 0.
//     Raise wrB_done -> run starts on the next edge.
//   3 Pipeline alignment: probe the addrbA and addrbB sequence for element (1,2).
//     Expect A addresses 4,5,6,7 and B addresses 2,5,8,11 on consecutive cycles.
//     Exactly one weC follows, 2 cycles after the last issue.
//   4 Overflow: A row0 all 32'hFFFFFFFF, B all 2 -> C[0][*] = 32'hFFFFFFF8 without
//     the macro and 32'hFFFFFFFF with MATMUL_SAT_EN.
//   5 Reset mid-run: assert reset during WRITE of element 3.
//     Expect outputs 0 asynchronously and no further weC.
//     After release with both done inputs high, all 6 elements are rewritten correctly.
//   6 Done inputs dropped mid-run: C is still complete and correct.
//     mm_done stays high until reset.

Source files
------------

// File: rtl/matmul_c_engine.sv
// rtl/matmul_c_engine.sv - single-shot C = A*B consumer over 1-cycle-latency A/B read ports
// Optional MATMUL_SAT_EN: saturate each C element instead of truncating it.
module matmul_c_engine #(
  parameter int N  = 2,
  parameter int P  = 4,
  parameter int M  = 3,
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wrA_done,
  input  logic          wrB_done,
  output logic [AW-1:0] addrbA,
  input  logic [DW-1:0] doutbA,
  output logic [AW-1:0] addrbB,
  input  logic [DW-1:0] doutbB,
  output logic          weC,
  output logic [AW-1:0] addrC,
  output logic [DW-1:0] dinC,
  output logic          busy,
  output logic          mm_done
);

  localparam int PW    = 2 * DW;
  localparam int ACC_W = 2 * DW + $clog2(P);
  localparam logic [AW-1:0] K_LAST = AW'(P - 1);
  localparam logic [AW-1:0] I_LAST = AW'(N - 1);
  localparam logic [AW-1:0] J_LAST = AW'(M - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
  logic [AW-1:0]    a_row_q, a_row_d;
  logic [AW-1:0]    e_q, e_d;
  logic [AW-1:0]    addrbA_q, addrbA_d, addrbB_q, addrbB_d;
  logic             weC_q, weC_d;
  logic [AW-1:0]    addrC_q, addrC_d;
  logic [DW-1:0]    dinC_q, dinC_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             mac_en_q, mac_en_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [PW-1:0]    prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_row_q  <= '0;
      e_q      <= '0;
      addrbA_q <= '0;
      addrbB_q <= '0;
      weC_q    <= 1'b0;
      addrC_q  <= '0;
      dinC_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mac_en_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_row_q  <= a_row_d;
      e_q      <= e_d;
      addrbA_q <= addrbA_d;
      addrbB_q <= addrbB_d;
      weC_q    <= weC_d;
      addrC_q  <= addrC_d;
      dinC_q   <= dinC_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mac_en_q <= mac_en_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_row_d  = a_row_q;
    e_d      = e_q;
    addrbA_d = addrbA_q;
    addrbB_d = addrbB_q;
    weC_d    = 1'b0;
    addrC_d  = addrC_q;
    dinC_d   = dinC_q;
    busy_d   = busy_q;
    done_d   = done_q;
    // read data returns one cycle after each issue, so the MAC trails by one cycle
    mac_en_d = (state_q == S_ISSUE);
    prod     = PW'(doutbA) * PW'(doutbB);
    acc_d    = acc_q;
    if (state_q == S_ISSUE && k_q == '0) acc_d = '0;
    else if (mac_en_q)                   acc_d = acc_q + ACC_W'(prod);

    case (state_q)
      S_IDLE: begin
        if (wrA_done && wrB_done) begin
          state_d  = S_ISSUE;
          busy_d   = 1'b1;
          k_d      = '0;
          addrbA_d = a_row_q;
          addrbB_d = j_q;
        end
      end
      S_ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d      = k_q + 1'b1;
          addrbA_d = addrbA_q + 1'b1;
          addrbB_d = addrbB_q + AW'(M);
        end
      end
      S_DRAIN: begin
        // acc_d already holds the final product of this element
        state_d = S_WRITE;
        weC_d   = 1'b1;
        addrC_d = e_q;
`ifdef MATMUL_SAT_EN
        dinC_d  = (acc_d > ACC_W'({DW{1'b1}})) ? {DW{1'b1}} : acc_d[DW-1:0];
`else
        dinC_d  = acc_d[DW-1:0];
`endif
      end
      S_WRITE: begin
        e_d = e_q + 1'b1;
        k_d = '0;
        if (i_q == I_LAST && j_q == J_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (j_q == J_LAST) begin
          state_d  = S_ISSUE;
          j_d      = '0;
          i_d      = i_q + 1'b1;
          a_row_d  = a_row_q + AW'(P);
          addrbA_d = a_row_q + AW'(P);
          addrbB_d = '0;
        end else begin
          state_d  = S_ISSUE;
          j_d      = j_q + 1'b1;
          addrbA_d = a_row_q;
          addrbB_d = j_q + 1'b1;
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign addrbA  = addrbA_q;
  assign addrbB  = addrbB_q;
  assign weC     = weC_q;
  assign addrC   = addrC_q;
  assign dinC    = dinC_q;
  assign busy    = busy_q;
  assign mm_done = done_q;

endmodule

// File: tb/tb_matmul_c_engine.sv
// tb/tb_matmul_c_engine.sv - randomized self-checking bench for matmul_c_engine
module tb_matmul_c_engine;
  localparam int N = 2, P = 4, M = 3, DW = 32, AW = 8;
  localparam int NE = N * M, EL = P + 2;

  logic          clk = 1'b0, reset = 1'b1, wrA_done = 1'b0, wrB_done = 1'b0;
  logic [AW-1:0] addrbA, addrbB, addrC;
  logic [DW-1:0] doutbA = '0, doutbB = '0, dinC;
  logic          weC, busy, mm_done;

  logic [DW-1:0] a_mem [0:(1<<AW)-1];
  logic [DW-1:0] b_mem [0:(1<<AW)-1];
  logic [AW-1:0] wq_a [$];
  logic [DW-1:0] wq_d [$];
  logic [AW-1:0] log_a [0:NE*EL-1];
  logic [AW-1:0] log_b [0:NE*EL-1];
  logic          log_w [0:NE*EL-1];
  int            cyc = 0, start_cyc = 0, done_cyc = 0, lc, n_chk = 0, n_pass = 0;
  logic          busy_prev = 1'b0, done_prev = 1'b0, logging = 1'b0;

  always #5 clk = ~clk;

  matmul_c_engine #(.N(N), .P(P), .M(M), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wrA_done(wrA_done), .wrB_done(wrB_done),
    .addrbA(addrbA), .doutbA(doutbA), .addrbB(addrbB), .doutbB(doutbB),
    .weC(weC), .addrC(addrC), .dinC(dinC), .busy(busy), .mm_done(mm_done)
  );

  always @(posedge clk) begin
    doutbA <= a_mem[addrbA];
    doutbB <= b_mem[addrbB];
    cyc    <= cyc + 1;
  end

  always @(negedge clk) begin
    if (weC) begin
      wq_a.push_back(addrC);
      wq_d.push_back(dinC);
    end
    if (busy && !busy_prev) start_cyc = cyc;
    if (mm_done && !done_prev) done_cyc = cyc;
    if (logging && busy) begin
      lc = cyc - start_cyc;
      if (lc >= 0 && lc < NE * EL) begin
        log_a[lc] = addrbA;
        log_b[lc] = addrbB;
        log_w[lc] = weC;
      end
    end
    busy_prev = busy;
    done_prev = mm_done;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] exp_c(input int i, input int j);
    logic [127:0] s = '0;
    for (int k = 0; k < P; k++) s += 128'(a_mem[i*P+k]) * 128'(b_mem[k*M+j]);
`ifdef MATMUL_SAT_EN
    if (s > 128'hFFFF_FFFF) return '1;
`endif
    return s[DW-1:0];
  endfunction

  task automatic fill_rand();
    for (int x = 0; x < N * P; x++) a_mem[x] = $urandom;
    for (int x = 0; x < P * M; x++) b_mem[x] = $urandom;
  endtask

  task automatic do_reset();
    wrA_done = 1'b0;
    wrB_done = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wq_a.delete();
    wq_d.delete();
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!mm_done && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_timeout"}, mm_done, 1'b1);
  endtask

  task automatic check_writes(input string tag);
    int n;
    n = (wq_a.size() < NE) ? wq_a.size() : NE;
    check({tag, "_nwrites"}, wq_a.size(), NE);
    for (int e = 0; e < n; e++) begin
      check($sformatf("%s_addr%0d", tag, e), wq_a[e], e);
      check($sformatf("%s_data%0d", tag, e), wq_d[e], exp_c(e / M, e % M));
    end
  endtask

  task automatic run_full(input string tag);
    wrA_done = 1'b1;
    wrB_done = 1'b1;
    wait_done(tag);
    @(negedge clk);
    check_writes(tag);
  endtask

  initial begin
    logic [DW-1:0] nom [0:NE-1];
    logic [DW-1:0] ovf;
    logic          any_busy, any_we, any_addr;
    nom[0] = 700;  nom[1] = 800;  nom[2] = 900;
    nom[3] = 1580; nom[4] = 1840; nom[5] = 2100;
    for (int x = 0; x < (1 << AW); x++) begin
      a_mem[x] = '0;
      b_mem[x] = '0;
    end

    // reset values
    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_done", mm_done, 1'b0);
    check("rst_we", weC, 1'b0);
    check("rst_addrA", addrbA, 0);
    check("rst_addrB", addrbB, 0);
    check("rst_addrC", addrC, 0);
    check("rst_dinC", dinC, 0);

    // nominal matrices, latency and per-cycle address alignment
    for (int x = 0; x < N * P; x++) a_mem[x] = x + 1;
    for (int x = 0; x < P * M; x++) b_mem[x] = 10 * (x + 1);
    logging = 1'b1;
    run_full("nom");
    logging = 1'b0;
    for (int e = 0; e < NE && e < wq_d.size(); e++) check($sformatf("nom_const%0d", e), wq_d[e], nom[e]);
    // edges counted inclusive of the start edge
    check("nom_latency", done_cyc - start_cyc + 1, NE * EL + 1);
    for (int c = 0; c < NE * EL; c++) begin
      int e, o;
      e = c / EL;
      o = c % EL;
      check($sformatf("align_we_c%0d", c), log_w[c], (o == EL - 1));
      if (o < P) begin
        check($sformatf("align_A_c%0d", c), log_a[c], (e / M) * P + o);
        check($sformatf("align_B_c%0d", c), log_b[c], o * M + (e % M));
      end
    end

    // gating: only A ready
    do_reset();
    any_busy = 1'b0; any_we = 1'b0; any_addr = 1'b0;
    wrA_done = 1'b1;
    repeat (20) begin
      @(negedge clk);
      any_busy |= busy;
      any_we   |= weC;
      any_addr |= (|addrbA) | (|addrbB) | (|addrC);
    end
    check("gate_busy", any_busy, 1'b0);
    check("gate_we", any_we, 1'b0);
    check("gate_addr", any_addr, 1'b0);
    fill_rand();
    wrB_done = 1'b1;
    @(posedge clk);
    #1 check("gate_start", busy, 1'b1);
    wait_done("gate");
    @(negedge clk);
    check_writes("gate");

    // overflow: A row 0 saturated, B all 2
    do_reset();
    fill_rand();
    for (int k = 0; k < P; k++) a_mem[k] = '1;
    for (int x = 0; x < P * M; x++) b_mem[x] = 2;
`ifdef MATMUL_SAT_EN
    ovf = 32'hFFFF_FFFF;
`else
    ovf = 32'hFFFF_FFF8;
`endif
    run_full("ovf");
    for (int j = 0; j < M && j < wq_d.size(); j++) check($sformatf("ovf_row0_%0d", j), wq_d[j], ovf);

    // reset asserted during WRITE of element 3
    do_reset();
    fill_rand();
    wrA_done = 1'b1;
    wrB_done = 1'b1;
    begin
      int t = 0;
      while (!(weC && addrC == 3) && t < 200) begin
        @(negedge clk);
        t++;
      end
      check("midrst_reach", weC && addrC == 3, 1'b1);
    end
    #1 reset = 1'b1;
    #1;
    check("midrst_we", weC, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_outs", {addrbA, addrbB, addrC, dinC}, 0);
    repeat (3) @(negedge clk);
    wq_a.delete();
    wq_d.delete();
    repeat (3) @(negedge clk);
    check("midrst_nowrite", wq_a.size(), 0);
    fill_rand();
    reset = 1'b0;
    @(posedge clk);
    #1 check("midrst_restart", busy, 1'b1);
    wait_done("midrst");
    @(negedge clk);
    check_writes("midrst");

    // done inputs dropped mid-run
    do_reset();
    fill_rand();
    wrA_done = 1'b1;
    wrB_done = 1'b1;
    repeat (5) @(negedge clk);
    wrA_done = 1'b0;
    wrB_done = 1'b0;
    wait_done("drop");
    @(negedge clk);
    check_writes("drop");
    repeat (10) @(negedge clk);
    check("drop_hold_done", mm_done, 1'b1);
    check("drop_hold_busy", busy, 1'b0);
    check("drop_no_extra", wq_a.size(), NE);

    // further random runs
    for (int r = 0; r < 3; r++) begin
      do_reset();
      fill_rand();
      run_full($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
